// File: rtl/pulse_stretcher_if.sv
// Grouped pulse-stretcher signals: event inputs, overrun clears and the per-channel outputs.
// The master drives pulses and clears; the slave (the stretcher) drives level, done and overrun.
interface pulse_stretcher_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] pulse_in;
    logic [WIDTH-1:0] overrun_clr;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] done;
    logic [WIDTH-1:0] overrun;

    modport master (
        output pulse_in,
        output overrun_clr,
        input  level_out,
        input  done,
        input  overrun
    );

    modport slave (
        input  pulse_in,
        input  overrun_clr,
        output level_out,
        output done,
        output overrun
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Per-channel pulse-to-level converter: each input pulse opens a LENGTH-cycle window on level_out,
// with optional retrigger, a one-cycle done at the window end and a sticky overrun flag.
module pulse_stretcher #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned LENGTH    = 4,
    parameter int unsigned RETRIGGER = 1
) (
    input logic              clk,
    input logic              rst_n,
    pulse_stretcher_if.slave bus
);
    localparam int unsigned CntW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(LENGTH - 1);
    localparam bit Retrig = (RETRIGGER != 0);

    if (LENGTH < 1 || LENGTH > 65536) begin : gen_length_check
        $error("pulse_stretcher: LENGTH must be in the range 1 to 65536");
    end

    typedef enum logic {StIdle, StActive} state_e;

    state_e          state_q [WIDTH];
    state_e          state_d [WIDTH];
    logic [CntW-1:0] cnt_q   [WIDTH];
    logic [CntW-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] done_q, done_d;
    logic [WIDTH-1:0] overrun_q, overrun_d;
    logic [WIDTH-1:0] ovr_set;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            done_d[i]  = 1'b0;
            ovr_set[i] = 1'b0;
            unique case (state_q[i])
                StIdle: begin
                    if (bus.pulse_in[i]) begin
                        state_d[i] = StActive;
                        cnt_d[i]   = CntMax;
                    end
                end
                StActive: begin
                    if (cnt_q[i] != '0) begin
                        if (bus.pulse_in[i] && Retrig) begin
                            cnt_d[i] = CntMax;
                        end else begin
                            cnt_d[i]   = cnt_q[i] - 1'b1;
                            ovr_set[i] = bus.pulse_in[i];
                        end
                    end else if (bus.pulse_in[i]) begin
                        // Last cycle of the window: chain a fresh window with no gap.
                        cnt_d[i] = CntMax;
                    end else begin
                        state_d[i] = StIdle;
                        done_d[i]  = 1'b1;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = '0;
                end
            endcase
        end
        // Set wins over a simultaneous clear.
        overrun_d = (overrun_q & ~bus.overrun_clr) | ovr_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
            done_q    <= '0;
            overrun_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            bus.level_out[i] = (state_q[i] == StActive);
        end
    end

    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: three instances (retrigger, no-retrigger, LENGTH=1) share
// stimulus; a deadline-based reference model queues expected outputs and a monitor checks them.
module tb_pulse_stretcher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pulse_stretcher_if #(.WIDTH(2)) ifr ();
    pulse_stretcher_if #(.WIDTH(2)) ifn ();
    pulse_stretcher_if #(.WIDTH(1)) if1 ();

    pulse_stretcher #(.WIDTH(2), .LENGTH(4), .RETRIGGER(1)) dut_r (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifr.slave)
    );
    pulse_stretcher #(.WIDTH(2), .LENGTH(4), .RETRIGGER(0)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifn.slave)
    );
    pulse_stretcher #(.WIDTH(1), .LENGTH(1), .RETRIGGER(1)) dut_1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    // Expected {level, done, overrun} per instance: r[14:9], n[8:3], l1[2:0].
    logic [14:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int edge_n = 0;
    bit driving = 1'b1;

    // Model state: the edge at which each window ends (level first low) and the overrun flag.
    int dl_r[2];
    int dl_n[2];
    int dl_1;
    bit ov_r[2];
    bit ov_n[2];
    bit ov_1;

    task automatic chan(input bit p, input bit c, input bit rst, input bit retrig, input int len,
                        input int e, input int dl_i, input bit ov_i,
                        output int dl_o, output bit ov_o, output bit lvl, output bit dn);
        bit set;
        set = 1'b0;
        dn = 1'b0;
        dl_o = dl_i;
        if (rst) begin
            dl_o = -10;
            ov_o = 1'b0;
            lvl = 1'b0;
            return;
        end
        if (p) begin
            if (e < dl_i && !retrig) set = 1'b1;
            else dl_o = e + len;
        end else if (e == dl_i) begin
            dn = 1'b1;
        end
        ov_o = (ov_i && !c) || set;
        lvl = (e < dl_o);
    endtask

    task automatic step(input bit rst, input logic [1:0] p, input logic [1:0] c);
        logic [1:0] lr, dr, orr, ln, dn, onn;
        bit l, d, o;
        int dl;
        @(negedge clk);
        rst_n = ~rst;
        ifr.pulse_in = p;
        ifn.pulse_in = p;
        if1.pulse_in = p[0];
        ifr.overrun_clr = c;
        ifn.overrun_clr = c;
        if1.overrun_clr = c[0];
        for (int ch = 0; ch < 2; ch++) begin
            chan(p[ch], c[ch], rst, 1'b1, 4, edge_n, dl_r[ch], ov_r[ch], dl, o, l, d);
            dl_r[ch] = dl; ov_r[ch] = o; lr[ch] = l; dr[ch] = d; orr[ch] = o;
            chan(p[ch], c[ch], rst, 1'b0, 4, edge_n, dl_n[ch], ov_n[ch], dl, o, l, d);
            dl_n[ch] = dl; ov_n[ch] = o; ln[ch] = l; dn[ch] = d; onn[ch] = o;
        end
        chan(p[0], c[0], rst, 1'b1, 1, edge_n, dl_1, ov_1, dl, o, l, d);
        dl_1 = dl; ov_1 = o;
        exp_q.push_back({lr, dr, orr, ln, dn, onn, l, d, o});
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00);
    endtask

    // Monitor: outputs are presented every cycle, so each edge pops one expected entry.
    initial begin
        logic [14:0] exp_v;
        logic [14:0] act_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {ifr.level_out, ifr.done, ifr.overrun,
                         ifn.level_out, ifn.done, ifn.overrun,
                         if1.level_out, if1.done, if1.overrun};
                total += 3;
                if (act_v[14:9] !== exp_v[14:9]) begin
                    bad++;
                    $display("FAIL retrig edge %0d: {lvl,done,ovr} got %b want %b",
                             edge_n, act_v[14:9], exp_v[14:9]);
                end
                if (act_v[8:3] !== exp_v[8:3]) begin
                    bad++;
                    $display("FAIL noretrig edge %0d: {lvl,done,ovr} got %b want %b",
                             edge_n, act_v[8:3], exp_v[8:3]);
                end
                if (act_v[2:0] !== exp_v[2:0]) begin
                    bad++;
                    $display("FAIL len1 edge %0d: {lvl,done,ovr} got %b want %b",
                             edge_n, act_v[2:0], exp_v[2:0]);
                end
            end
        end
    end

    initial begin
        dl_1 = -10;
        ov_1 = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            dl_r[ch] = -10; dl_n[ch] = -10; ov_r[ch] = 1'b0; ov_n[ch] = 1'b0;
        end
        ifr.pulse_in = '0; ifn.pulse_in = '0; if1.pulse_in = '0;
        ifr.overrun_clr = '0; ifn.overrun_clr = '0; if1.overrun_clr = '0;

        // Reset held with pulses driven, then one quiet cycle after release.
        for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 2'b00);
        idle(2);
        // Single pulse.
        step(1'b0, 2'b01, 2'b00);
        idle(6);
        // Retrigger two edges later; channel 1 gets a lone pulse in parallel.
        step(1'b0, 2'b11, 2'b00);
        step(1'b0, 2'b00, 2'b00);
        step(1'b0, 2'b01, 2'b00);
        idle(8);
        // Dropped pulse, then clear together with another dropped pulse, then clear alone.
        step(1'b0, 2'b01, 2'b00);
        step(1'b0, 2'b00, 2'b00);
        step(1'b0, 2'b01, 2'b00);
        step(1'b0, 2'b01, 2'b01);
        idle(4);
        step(1'b0, 2'b00, 2'b01);
        idle(2);
        // Back-to-back at the last window cycle.
        step(1'b0, 2'b10, 2'b00);
        idle(3);
        step(1'b0, 2'b10, 2'b00);
        idle(6);
        // Reset mid-window.
        step(1'b0, 2'b11, 2'b00);
        step(1'b0, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b00);
        idle(6);
        // LENGTH=1 pattern 1,0,1,1 on channel 0.
        step(1'b0, 2'b01, 2'b00);
        step(1'b0, 2'b00, 2'b00);
        step(1'b0, 2'b01, 2'b00);
        step(1'b0, 2'b01, 2'b00);
        idle(3);
        // Held-high input for several cycles.
        for (int i = 0; i < 7; i++) step(1'b0, 2'b11, 2'b00);
        idle(8);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [1:0] p, c;
            bit r;
            p[0] = ($urandom_range(0, 99) < 30);
            p[1] = ($urandom_range(0, 99) < 45);
            c[0] = ($urandom_range(0, 99) < 10);
            c[1] = ($urandom_range(0, 99) < 10);
            r = ($urandom_range(0, 199) == 0);
            step(r, p, c);
        end
        idle(2);
        driving = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: queue left %0d entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Per-channel pulse-to-level converter, the inverse of the rising-edge detector: it takes one-cycle event pulses and turns each into a level held high for a fixed, parameterized number of cycles. A counter per channel runs each window, and pulses that arrive during a window either extend it (retrigger) or are dropped and flagged (overrun). A one-cycle `done` pulse marks each window's end. Typical uses are widening single-cycle core events (traps, stalls, CSR strobes) for LEDs, slow peripherals or debug capture, and holding request levels generated from edge-detected inputs.

## Interface
- `WIDTH`, 1: number of independent channels.
- `LENGTH`, 4: window length in cycles. Legal range is 1 to 2^16; anything else is an elaboration error.
- `RETRIGGER`, 1: 1 means a pulse during a window restarts the window; 0 means such a pulse is dropped and flagged as overrun.
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `pulse_in`  in  WIDTH  event pulses; any cycle sampled high is one event.
- `overrun_clr`  in  WIDTH  per-channel clear for the `overrun` flag.
- `level_out`  out  WIDTH  registered stretched level.
- `done`  out  WIDTH  registered one-cycle pulse on the cycle `level_out` falls.
- `overrun`  out  WIDTH  sticky registered flag: a pulse was dropped.

## Operation
Each channel is independent. Each has a 2-state FSM, IDLE/ACTIVE, and a down-counter `cnt` of width $clog2(LENGTH), minimum 1 bit.

IDLE:
- `pulse_in`=1: go to ACTIVE, `cnt`<=LENGTH-1.
- Otherwise: stay in IDLE.

ACTIVE with `cnt`>0:
- `pulse_in`=1 and RETRIGGER=1: `cnt`<=LENGTH-1.
- `pulse_in`=1 and RETRIGGER=0: pulse dropped, `overrun`<=1, `cnt` decrements.
- `pulse_in`=0: `cnt` decrements.

ACTIVE with `cnt`==0 (last cycle of the window):
- `pulse_in`=1: start a new window back-to-back, `cnt`<=LENGTH-1, stay in ACTIVE. `level_out` stays continuously high, no `done`, no overrun. This applies in both RETRIGGER modes.
- `pulse_in`=0: go to IDLE, `done`<=1 for one cycle.

Outputs:
- `level_out` = (state==ACTIVE). It is registered, never combinational from `pulse_in`.
- `overrun`: a set and `overrun_clr` in the same cycle leaves it set (set wins). A clear with no set clears it on the next edge.

Parameter and input corner cases:
- LENGTH=1: `cnt` is always 0, so `level_out` is `pulse_in` delayed by one cycle. `overrun` never sets and RETRIGGER has no effect.
- `pulse_in` held high for K cycles, RETRIGGER=1: `level_out` stays high for K+LENGTH-1 cycles.
- `pulse_in` held high for K cycles, RETRIGGER=0: windows run back-to-back until the input falls. `overrun` sets if any dropped pulse lands at `cnt`>0.

## Timing
- Reset: `rst_n` sampled low at an edge forces, for all channels, state IDLE, `cnt`=0, `level_out`=0, `done`=0, `overrun`=0.
  - Reset in the middle of a window terminates it immediately with no `done`.
  - A `pulse_in` sampled in the same cycle as reset is ignored.
  - After `rst_n` returns high, the first `pulse_in` is accepted at the first edge with `rst_n`=1.
- Latency: a pulse sampled at edge t gives `level_out`=1 in cycles t+1 through t+LENGTH, assuming no retrigger.
- `done`: asserted exactly in cycle t+LENGTH+1, the first cycle with `level_out`=0.
- Retrigger: a pulse sampled at edge r within an active window moves the fall to cycle r+LENGTH+1.
- Overrun: `overrun` rises in the cycle after the dropped pulse is sampled.
- Independence: channels never interact. Simultaneous pulses on several channels are all handled in the same cycle.

## Test plan
- **Reset:** WIDTH=2, LENGTH=4. Hold `rst_n`=0 for 3 cycles while driving `pulse_in`=2'b11 → all outputs are 0 throughout and one cycle after release.
- **Reset mid-window:** pulse at edge 0, `rst_n`=0 sampled at edge 2 → `level_out`=0 from cycle 3, and `done` never asserts.
- **Single pulse:** LENGTH=4, RETRIGGER=1, one-cycle pulse at edge 10 → `level_out`=1 in cycles 11–14, `done`=1 in cycle 15 only.
- **Retrigger:** LENGTH=4, RETRIGGER=1, pulses at edges 10 and 12 → `level_out` high in cycles 11–16, a single `done` in cycle 17, `overrun`=0.
- **No retrigger, overrun and clear:** LENGTH=4, RETRIGGER=0, pulses at edges 10 and 12 → `level_out` high in cycles 11–14 and `done` in cycle 15. `overrun` rises in cycle 13.
  - `overrun_clr` together with a new dropped pulse → `overrun` stays 1.
  - `overrun_clr` alone → `overrun` is 0 the next cycle.
- **Back-to-back boundary and LENGTH=1:** LENGTH=4, pulses at edges 10 and 14 → `level_out` continuously high in cycles 11–18, no `done` until cycle 19, `overrun`=0.
  - With LENGTH=1, `pulse_in` pattern 1,0,1,1 → `level_out` shows the same pattern one cycle later, with `done` after each fall.
